// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - control sequencer for an iterative AES-128 encryption datapath
// Moore-decoded strobes; round counter, round constant and mixcolumns arm flag are registered.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       finish,
  output logic       busy,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       st_load,
  output logic [1:0] st_sel,
  output logic       key_load,
  output logic       key_step,
  output logic       mc_start,
  input  logic       mc_finish
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND_MC,
    S_ROUND_LD,
    S_FINAL,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q,  rcon_d;
  logic       armed_q, armed_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    armed_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        round_d = 4'd1;
        rcon_d  = 8'h01;
        state_d = S_ROUND_MC;
      end
      S_ROUND_MC: begin
        // armed_q is low on the first cycle, masking a finish left over from the last round
        armed_d = 1'b1;
        if (armed_q && mc_finish) state_d = S_ROUND_LD;
      end
      S_ROUND_LD: begin
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        state_d = ((round_q + 4'd1) == LAST_ROUND) ? S_FINAL : S_ROUND_MC;
      end
      S_FINAL: begin
        rcon_d  = xtime(rcon_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!start && (state_q inside {S_INIT, S_ROUND_MC, S_ROUND_LD, S_FINAL})) begin
      state_d = S_IDLE;
      armed_d = 1'b0;
    end
    if (state_d == S_IDLE) begin
      round_d = 4'd0;
      rcon_d  = 8'h01;
    end
  end

  assign finish   = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign round    = round_q;
  assign rcon     = rcon_q;
  assign st_load  = (state_q == S_INIT) || (state_q == S_ROUND_LD) || (state_q == S_FINAL);
  assign st_sel   = (state_q == S_ROUND_LD) ? 2'b01 : ((state_q == S_FINAL) ? 2'b10 : 2'b00);
  assign key_load = (state_q == S_INIT);
  assign key_step = (state_q == S_ROUND_LD) || (state_q == S_FINAL);
  assign mc_start = (state_q == S_ROUND_MC);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl with an AES-128 reference datapath
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, mc_finish;
  logic       finish, busy, st_load, key_load, key_step, mc_start;
  logic [3:0] round;
  logic [7:0] rcon;
  logic [1:0] st_sel;

  logic       start2, mc_finish2;
  logic       finish2, busy2, st_load2, key_load2, key_step2, mc_start2;
  logic [3:0] round2;
  logic [7:0] rcon2;
  logic [1:0] st_sel2;

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .busy(busy),
    .round(round), .rcon(rcon), .st_load(st_load), .st_sel(st_sel),
    .key_load(key_load), .key_step(key_step), .mc_start(mc_start), .mc_finish(mc_finish)
  );

  aes_round_ctrl #(.NR(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .finish(finish2), .busy(busy2),
    .round(round2), .rcon(rcon2), .st_load(st_load2), .st_sel(st_sel2),
    .key_load(key_load2), .key_step(key_step2), .mc_start(mc_start2), .mc_finish(mc_finish2)
  );

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0]   sbox_t [256];
  logic [7:0]   exp_rcon[$], exp_rcon2[$];
  logic [1:0]   exp_sel[$],  exp_sel2[$];
  logic [127:0] exp_ct[$];

  int cnt_kl, cnt_ks, cnt_sl, mc_run, mc_segs, mc_min;
  int cnt_ks2, mc_run2, mc_segs2, mc_min2;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) b = 8'(j);
      sbox_t[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox_t[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103 - 32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Reference datapath and mixcolumns unit driven only by the controller's strobes
  logic [127:0] dp_state, dp_key, mc_res;
  always @(posedge clk) begin
    mc_finish  <= rst ? 1'b0 : mc_start;
    mc_finish2 <= rst ? 1'b0 : mc_start2;
    if (mc_start) mc_res <= mix_cols(sub_shift(dp_state));
    if (key_load)      dp_key <= KEY;
    else if (key_step) dp_key <= next_key(dp_key, rcon);
    if (st_load) begin
      case (st_sel)
        2'b00:   dp_state <= PT ^ KEY;
        2'b01:   dp_state <= mc_res ^ next_key(dp_key, rcon);
        default: dp_state <= sub_shift(dp_state) ^ next_key(dp_key, rcon);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [7:0] er;
      logic [1:0] es;
      if (key_load) cnt_kl++;
      if (st_load) begin
        cnt_sl++;
        n_checks++;
        if (exp_sel.size() == 0) begin
          n_fail++;
          $display("FAIL sel_sb: st_load with st_sel=%b, required no st_load", st_sel);
        end else begin
          es = exp_sel.pop_front();
          if (st_sel !== es) begin
            n_fail++;
            $display("FAIL sel_sb: st_sel=%b required %b", st_sel, es);
          end
        end
      end
      if (key_step) begin
        cnt_ks++;
        n_checks++;
        if (exp_rcon.size() == 0) begin
          n_fail++;
          $display("FAIL rcon_sb: key_step with rcon=%h, required no key_step", rcon);
        end else begin
          er = exp_rcon.pop_front();
          if (rcon !== er) begin
            n_fail++;
            $display("FAIL rcon_sb: rcon=%h required %h", rcon, er);
          end
        end
      end
      if (mc_start) mc_run++;
      else if (mc_run > 0) begin
        mc_segs++;
        if (mc_run < mc_min) mc_min = mc_run;
        mc_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [7:0] er;
      logic [1:0] es;
      if (st_load2) begin
        n_checks++;
        if (exp_sel2.size() == 0) begin
          n_fail++;
          $display("FAIL sel2_sb: st_load with st_sel=%b, required no st_load", st_sel2);
        end else begin
          es = exp_sel2.pop_front();
          if (st_sel2 !== es) begin
            n_fail++;
            $display("FAIL sel2_sb: st_sel=%b required %b", st_sel2, es);
          end
        end
      end
      if (key_step2) begin
        cnt_ks2++;
        n_checks++;
        if (exp_rcon2.size() == 0) begin
          n_fail++;
          $display("FAIL rcon2_sb: key_step with rcon=%h, required no key_step", rcon2);
        end else begin
          er = exp_rcon2.pop_front();
          if (rcon2 !== er) begin
            n_fail++;
            $display("FAIL rcon2_sb: rcon=%h required %h", rcon2, er);
          end
        end
      end
      if (mc_start2) mc_run2++;
      else if (mc_run2 > 0) begin
        mc_segs2++;
        if (mc_run2 < mc_min2) mc_min2 = mc_run2;
        mc_run2 = 0;
      end
    end
  end

  task automatic clear_sb();
    exp_rcon.delete(); exp_sel.delete(); exp_ct.delete();
    exp_rcon2.delete(); exp_sel2.delete();
    cnt_kl = 0; cnt_ks = 0; cnt_sl = 0; mc_run = 0; mc_segs = 0; mc_min = 1000;
    cnt_ks2 = 0; mc_run2 = 0; mc_segs2 = 0; mc_min2 = 1000;
  endtask

  task automatic push_run();
    for (int i = 0; i < 10; i++) exp_rcon.push_back(rc_tab[i]);
    exp_sel.push_back(2'b00);
    for (int i = 0; i < 9; i++) exp_sel.push_back(2'b01);
    exp_sel.push_back(2'b10);
    exp_ct.push_back(CT);
  endtask

  // Entered #1 after an edge with the controller idle; that cycle is cycle 0
  task automatic run_to_finish(input int budget, output int fin_cyc, output int init_cyc);
    fin_cyc  = -1;
    init_cyc = -1;
    start    = 1'b1;
    for (int c = 1; c <= budget && fin_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (st_load && key_load && init_cyc < 0) init_cyc = c;
      if (finish) fin_cyc = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({finish, busy, st_load, key_load, key_step, mc_start, st_sel, round, rcon} !== {6'b0, 2'b00, 4'd0, 8'h01}) begin
      n_fail++;
      $display("FAIL reset_outputs: got fin=%b busy=%b stl=%b kl=%b ks=%b mcs=%b sel=%b round=%0d rcon=%h, required zeros and rcon=01",
               finish, busy, st_load, key_load, key_step, mc_start, st_sel, round, rcon);
    end
    n_checks++;
    if ({finish2, busy2, round2, rcon2} !== {2'b0, 4'd0, 8'h01}) begin
      n_fail++;
      $display("FAIL reset_outputs_nr2: fin=%b busy=%b round=%0d rcon=%h, required 0 0 0 01", finish2, busy2, round2, rcon2);
    end
  endtask

  task automatic test_encrypt();
    int fc, ic;
    logic [127:0] ect;
    clear_sb();
    push_run();
    run_to_finish(200, fc, ic);
    n_checks++; if (fc != 30) begin n_fail++; $display("FAIL finish_cycle: got %0d required 30", fc); end
    n_checks++; if (ic != 1) begin n_fail++; $display("FAIL init_cycle: got %0d required 1", ic); end
    ect = exp_ct.pop_front();
    n_checks++; if (dp_state !== ect) begin n_fail++; $display("FAIL ciphertext: got %h required %h", dp_state, ect); end
    n_checks++; if (cnt_ks != 10) begin n_fail++; $display("FAIL key_step_count: got %0d required 10", cnt_ks); end
    n_checks++; if (cnt_kl != 1) begin n_fail++; $display("FAIL key_load_count: got %0d required 1", cnt_kl); end
    n_checks++; if (cnt_sl != 11) begin n_fail++; $display("FAIL st_load_count: got %0d required 11", cnt_sl); end
    n_checks++;
    if (exp_rcon.size() != 0 || exp_sel.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: rcon left %0d sel left %0d, required 0 0", exp_rcon.size(), exp_sel.size());
    end
    n_checks++; if (mc_segs != 9) begin n_fail++; $display("FAIL mc_rounds: got %0d required 9", mc_segs); end
    n_checks++; if (mc_min < 2) begin n_fail++; $display("FAIL mc_min_len: got %0d required >=2", mc_min); end
    n_checks++;
    if (round !== 4'd10 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_state: round=%0d busy=%b, required 10 0", round, busy);
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (finish !== 1'b0 || round !== 4'd0 || rcon !== 8'h01) begin
      n_fail++;
      $display("FAIL done_to_idle: fin=%b round=%0d rcon=%h, required 0 0 01", finish, round, rcon);
    end
  endtask

  task automatic test_abort();
    int n, saw_fin;
    clear_sb();
    push_run();
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(round == 4'd5 && mc_start) && n < 200);
    n_checks++; if (n >= 200) begin n_fail++; $display("FAIL abort_reach_r5: round=%0d after %0d cycles, required round 5", round, n); end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mc_start, st_load, key_load, key_step, finish} !== 6'b0 || round !== 4'd0 || rcon !== 8'h01) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b mcs=%b stl=%b kl=%b ks=%b fin=%b round=%0d rcon=%h, required zeros round 0 rcon 01",
               busy, mc_start, st_load, key_load, key_step, finish, round, rcon);
    end
    n_checks++;
    if (exp_rcon.size() != 6 || exp_sel.size() != 6) begin
      n_fail++;
      $display("FAIL abort_progress: rcon left %0d sel left %0d, required 6 6", exp_rcon.size(), exp_sel.size());
    end
    saw_fin = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (finish || busy) saw_fin++;
    end
    n_checks++; if (saw_fin != 0) begin n_fail++; $display("FAIL abort_quiet: %0d active cycles, required 0", saw_fin); end
    clear_sb();
  endtask

  task automatic test_reset_mid();
    int n;
    clear_sb();
    push_run();
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(st_load && st_sel == 2'b01 && round == 4'd3) && n < 200);
    n_checks++; if (n >= 200) begin n_fail++; $display("FAIL rstmid_reach: round=%0d, required ROUND_LD of round 3", round); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({finish, busy, st_load, key_load, key_step, mc_start, st_sel, round, rcon} !== {6'b0, 2'b00, 4'd0, 8'h01}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: fin=%b busy=%b stl=%b kl=%b ks=%b mcs=%b sel=%b round=%0d rcon=%h, required zeros rcon 01",
               finish, busy, st_load, key_load, key_step, mc_start, st_sel, round, rcon);
    end
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: busy=%b required 0", busy); end
    clear_sb();
  endtask

  task automatic test_hold_done();
    int fc, ic, bad;
    logic [127:0] ect;
    clear_sb();
    push_run();
    run_to_finish(200, fc, ic);
    n_checks++; if (fc != 30) begin n_fail++; $display("FAIL hold_finish_cycle: got %0d required 30", fc); end
    ect = exp_ct.pop_front();
    n_checks++; if (dp_state !== ect) begin n_fail++; $display("FAIL hold_ciphertext: got %h required %h", dp_state, ect); end
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!finish || busy || st_load || key_load || key_step || round != 4'd10) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_done: %0d bad cycles, required 0", bad); end
    n_checks++; if (cnt_kl != 1) begin n_fail++; $display("FAIL hold_no_retrigger: key_load count %0d required 1", cnt_kl); end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL hold_release: finish=%b required 0", finish); end
  endtask

  task automatic test_nr2();
    int fc;
    clear_sb();
    exp_rcon2.push_back(8'h01);
    exp_rcon2.push_back(8'h02);
    exp_sel2.push_back(2'b00);
    exp_sel2.push_back(2'b01);
    exp_sel2.push_back(2'b10);
    fc = -1;
    start2 = 1'b1;
    for (int c = 1; c <= 100 && fc < 0; c++) begin
      @(posedge clk); #1;
      if (finish2) fc = c;
    end
    n_checks++; if (fc != 6) begin n_fail++; $display("FAIL nr2_finish_cycle: got %0d required 6", fc); end
    n_checks++; if (round2 !== 4'd2) begin n_fail++; $display("FAIL nr2_round: got %0d required 2", round2); end
    n_checks++; if (cnt_ks2 != 2) begin n_fail++; $display("FAIL nr2_key_steps: got %0d required 2", cnt_ks2); end
    n_checks++;
    if (mc_segs2 != 1 || mc_min2 < 2) begin
      n_fail++;
      $display("FAIL nr2_mc: segments %0d min len %0d, required 1 and >=2", mc_segs2, mc_min2);
    end
    n_checks++;
    if (exp_rcon2.size() != 0 || exp_sel2.size() != 0) begin
      n_fail++;
      $display("FAIL nr2_sb_drained: rcon left %0d sel left %0d, required 0 0", exp_rcon2.size(), exp_sel2.size());
    end
    start2 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (finish2 !== 1'b0) begin n_fail++; $display("FAIL nr2_release: finish=%b required 0", finish2); end
  endtask

  initial begin
    clear_sb();
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_encrypt();
    test_abort();
    test_encrypt();
    test_reset_mid();
    test_hold_done();
    test_nr2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
